// File: rtl/reg_scoreboard_pkg.sv
// Shared types and sizes for the issue-stage register scoreboard.
// One entry per architectural register: a busy flag plus a countdown to forward availability.
package reg_scoreboard_pkg;

    localparam int NREG      = 32;
    localparam int NISSUE    = 2;
    localparam int NWB       = 2;
    localparam int LAT_W     = 3;
    localparam int REGADDR_W = 5;

    typedef logic [REGADDR_W-1:0] regaddr_t;
    typedef logic [LAT_W-1:0]     lat_t;

    typedef struct packed {
        logic busy;
        lat_t cnt;
    } sb_entry_t;

    // A latency of 0 still takes one cycle to reach a forward source.
    function automatic lat_t eff_lat(input lat_t lat);
        return (lat == '0) ? lat_t'(1) : lat;
    endfunction

endpackage

// File: rtl/reg_scoreboard_hazard_check.sv
// RAW and WAW hazard check for one issue slot against the current (pre-update) scoreboard.
// Intra-bundle and in-order terms are resolved in the top level.
module reg_scoreboard_hazard_check
    import reg_scoreboard_pkg::*;
(
    input  sb_entry_t [NREG-1:0] entries,
    input  logic                 wen,
    input  regaddr_t             rd,
    input  lat_t                 lat,
    input  regaddr_t             rs1,
    input  regaddr_t             rs2,
    output logic                 ok
);

    logic raw1;
    logic raw2;
    logic waw;

    // busy with cnt==0 means the value already sits on a bypass source.
    assign raw1 = (rs1 != '0) && entries[rs1].busy && (entries[rs1].cnt != '0);
    assign raw2 = (rs2 != '0) && entries[rs2].busy && (entries[rs2].cnt != '0);

    // An older write landing after ours would leave a stale value in the register.
    assign waw  = wen && (rd != '0) && entries[rd].busy && (entries[rd].cnt > eff_lat(lat));

    assign ok   = !(raw1 || raw2 || waw);

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-stage register scoreboard: set on issue, count down per cycle, clear on writeback/flush.
// Optional SCOREBOARD_PERF_EN adds a 64-bit stall_cycles counter for slot 0.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic     [NISSUE-1:0]    iss_valid,
    input  logic     [NISSUE-1:0]    iss_wen,
    input  regaddr_t [NISSUE-1:0]    iss_rd,
    input  lat_t     [NISSUE-1:0]    iss_lat,
    input  regaddr_t [NISSUE-1:0]    iss_rs1,
    input  regaddr_t [NISSUE-1:0]    iss_rs2,
    input  logic     [NISSUE-1:0]    iss_fire,
    input  logic     [NWB-1:0]       wb_wen,
    input  regaddr_t [NWB-1:0]       wb_waddr,
    input  logic                     flush,
    output logic     [NISSUE-1:0]    issue_ok,
    output logic     [NREG-1:0]      busy_vec
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic     [63:0]          stall_cycles
`endif
);

    sb_entry_t [NREG-1:0] entries;
    sb_entry_t [NREG-1:0] entries_nxt;
    logic      [NISSUE-1:0] hz_ok;
    logic      slot0_writes;
    logic      intra;

    for (genvar s = 0; s < NISSUE; s++) begin : g_hz
        reg_scoreboard_hazard_check u_hz (
            .entries (entries),
            .wen     (iss_wen[s]),
            .rd      (iss_rd[s]),
            .lat     (iss_lat[s]),
            .rs1     (iss_rs1[s]),
            .rs2     (iss_rs2[s]),
            .ok      (hz_ok[s])
        );
    end

    // Slot 1 cannot consume or overwrite what slot 0 produces in the same bundle.
    assign slot0_writes = iss_valid[0] && iss_wen[0] && (iss_rd[0] != '0);
    assign intra        = slot0_writes && ((iss_rd[0] == iss_rs1[1]) ||
                                           (iss_rd[0] == iss_rs2[1]) ||
                                           (iss_rd[0] == iss_rd[1]));

    assign issue_ok[0] = iss_valid[0] && hz_ok[0];
    assign issue_ok[1] = iss_valid[1] && hz_ok[1] && issue_ok[0] && !intra;

    // Later steps override earlier ones: decrement, writeback, flush, issue.
    always_comb begin
        entries_nxt = entries;
        for (int r = 0; r < NREG; r++) begin
            if (entries[r].busy && (entries[r].cnt != '0)) begin
                entries_nxt[r].cnt = entries[r].cnt - lat_t'(1);
            end
        end
        for (int w = 0; w < NWB; w++) begin
            if (wb_wen[w] && (wb_waddr[w] != '0)) begin
                entries_nxt[wb_waddr[w]] = '0;
            end
        end
        if (flush) begin
            entries_nxt = '0;
        end else begin
            for (int s = 0; s < NISSUE; s++) begin
                if (iss_fire[s] && iss_wen[s] && (iss_rd[s] != '0)) begin
                    entries_nxt[iss_rd[s]].busy = 1'b1;
                    entries_nxt[iss_rd[s]].cnt  = eff_lat(iss_lat[s]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries <= '0;
        end else begin
            entries <= entries_nxt;
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = entries[r].busy;
        end
    end

`ifdef SCOREBOARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (iss_valid[0] && !issue_ok[0] && !flush) begin
            stall_cycles <= stall_cycles + 64'd1;
        end
    end
`endif

    fire_needs_ok: assert property (@(posedge clk) disable iff (rst)
        ((iss_fire & ~issue_ok) == '0));

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with a time-based reference model and per-cycle compare.
// Build with SCOREBOARD_PERF_EN defined to also check stall_cycles.
module tb_reg_scoreboard;

    logic              clk;
    logic              rst;
    logic [1:0]        iss_valid;
    logic [1:0]        iss_wen;
    logic [1:0][4:0]   iss_rd;
    logic [1:0][2:0]   iss_lat;
    logic [1:0][4:0]   iss_rs1;
    logic [1:0][4:0]   iss_rs2;
    logic [1:0]        iss_fire;
    logic [1:0]        wb_wen;
    logic [1:0][4:0]   wb_waddr;
    logic              flush;
    logic [1:0]        issue_ok;
    logic [31:0]       busy_vec;
`ifdef SCOREBOARD_PERF_EN
    logic [63:0]       stall_cycles;
`endif

    logic [1:0]        want_fire;
    int                checks;
    int                failures;

    // Model: a register is pending until an absolute cycle number, not a countdown.
    bit                m_busy  [32];
    int                m_avail [32];
    int                cyc;
    longint            m_stall;

    reg_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_wen   (iss_wen),
        .iss_rd    (iss_rd),
        .iss_lat   (iss_lat),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_fire  (iss_fire),
        .wb_wen    (wb_wen),
        .wb_waddr  (wb_waddr),
        .flush     (flush),
        .issue_ok  (issue_ok),
        .busy_vec  (busy_vec)
`ifdef SCOREBOARD_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eff(input logic [2:0] l);
        return (l == 3'd0) ? 1 : int'(l);
    endfunction

    function automatic bit src_ready(input logic [4:0] x);
        return (x == 5'd0) || !m_busy[x] || (cyc >= m_avail[x]);
    endfunction

    function automatic logic [1:0] model_ok();
        logic [1:0] ok;
        for (int s = 0; s < 2; s++) begin
            ok[s] = iss_valid[s] && src_ready(iss_rs1[s]) && src_ready(iss_rs2[s]) &&
                    !(iss_wen[s] && (iss_rd[s] != 5'd0) && m_busy[iss_rd[s]] &&
                      ((m_avail[iss_rd[s]] - cyc) > eff(iss_lat[s])));
        end
        if (iss_valid[0] && iss_wen[0] && (iss_rd[0] != 5'd0) &&
            ((iss_rd[0] == iss_rs1[1]) || (iss_rd[0] == iss_rs2[1]) || (iss_rd[0] == iss_rd[1])))
            ok[1] = 1'b0;
        ok[1] = ok[1] && ok[0];
        return ok;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_update();
        logic [1:0] ok;
        ok = model_ok();
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_busy[r]  = 1'b0;
                m_avail[r] = 0;
            end
            m_stall = 0;
        end else begin
            if (iss_valid[0] && !ok[0] && !flush) m_stall++;
            for (int w = 0; w < 2; w++)
                if (wb_wen[w] && (wb_waddr[w] != 5'd0)) m_busy[wb_waddr[w]] = 1'b0;
            if (flush) begin
                for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            end else begin
                for (int s = 0; s < 2; s++) begin
                    if (iss_fire[s] && iss_wen[s] && (iss_rd[s] != 5'd0)) begin
                        m_busy[iss_rd[s]]  = 1'b1;
                        m_avail[iss_rd[s]] = cyc + 1 + eff(iss_lat[s]);
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle();
        iss_valid = '0; iss_wen = '0; iss_rd = '0; iss_lat = '0;
        iss_rs1 = '0; iss_rs2 = '0; iss_fire = '0; want_fire = '0;
        wb_wen = '0; wb_waddr = '0; flush = 1'b0;
    endtask

    task automatic set_slot(input int s, input bit v, input bit w, input logic [4:0] rd,
                            input logic [2:0] lat, input logic [4:0] rs1, input logic [4:0] rs2,
                            input bit f);
        iss_valid[s] = v; iss_wen[s] = w; iss_rd[s] = rd; iss_lat[s] = lat;
        iss_rs1[s] = rs1; iss_rs2[s] = rs2; want_fire[s] = f;
    endtask

    // Only fire slots the model says are legal, so the DUT never sees an illegal fire.
    task automatic apply();
        iss_fire = want_fire & model_ok();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc = 0;
        m_stall = 0;
        forever begin
            @(posedge clk);
            model_update();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("cmp_issue_ok", issue_ok, model_ok());
                check("cmp_busy_vec", busy_vec, model_busy());
`ifdef SCOREBOARD_PERF_EN
                check("cmp_stall_cycles", stall_cycles, m_stall);
`endif
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state: independent readers issue freely.
        set_slot(0, 1, 0, 0, 0, 5, 6, 0); set_slot(1, 1, 0, 0, 0, 1, 2, 0); apply();
        @(negedge clk);
        check("rst_issue_ok", issue_ok, 2'b11);
        check("rst_busy_vec", busy_vec, 32'h0);
`ifdef SCOREBOARD_PERF_EN
        check("rst_stall", stall_cycles, 64'd0);
`endif
        tick();

        // x7 lat 3: reader blocked while cnt is 3,2,1; bypass once cnt reaches 0.
        idle(); set_slot(0, 1, 1, 7, 3, 0, 0, 1); apply(); tick();
        idle(); set_slot(0, 1, 0, 0, 0, 7, 0, 0); apply();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("raw_x7_blocked", issue_ok[0], 1'b0);
            tick();
        end
        @(negedge clk);
        check("raw_x7_bypass", issue_ok[0], 1'b1);
        check("x7_busy_at_bypass", busy_vec[7], 1'b1);
        tick();
        idle(); wb_wen = 2'b01; wb_waddr[0] = 5'd7; tick();
        idle();
        @(negedge clk);
        check("wb_clears_x7", busy_vec[7], 1'b0);
        tick();

        // Issue beats same-cycle writeback to the same register.
        idle(); set_slot(0, 1, 1, 7, 2, 0, 0, 1); apply(); tick();
        idle(); set_slot(0, 1, 1, 7, 2, 0, 0, 1); wb_wen = 2'b10; wb_waddr[1] = 5'd7; apply();
        @(negedge clk);
        check("waw_equal_lat_ok", issue_ok[0], 1'b1);
        tick();
        idle(); set_slot(0, 1, 0, 0, 0, 7, 0, 0); apply();
        @(negedge clk);
        check("issue_beats_wb_busy", busy_vec[7], 1'b1);
        check("issue_beats_wb_cnt2", issue_ok[0], 1'b0);
        tick();
        @(negedge clk);
        check("issue_beats_wb_cnt1", issue_ok[0], 1'b0);
        tick();
        @(negedge clk);
        check("issue_beats_wb_cnt0", issue_ok[0], 1'b1);
        tick();
        idle(); wb_wen = 2'b01; wb_waddr[0] = 5'd7; tick();

        // Intra-bundle dependencies.
        idle(); set_slot(0, 1, 1, 9, 1, 1, 2, 0); set_slot(1, 1, 0, 0, 0, 3, 9, 0); apply();
        @(negedge clk);
        check("intra_rs2", issue_ok, 2'b01);
        check("model_intra_rs2", model_ok(), 2'b01);
        tick();
        idle(); set_slot(0, 1, 1, 0, 1, 9, 9, 0); set_slot(1, 1, 1, 0, 1, 0, 9, 0); apply();
        @(negedge clk);
        check("intra_rd_zero", issue_ok, 2'b11);
        tick();
        idle(); set_slot(0, 1, 1, 9, 1, 1, 2, 0); set_slot(1, 1, 1, 9, 1, 0, 0, 0); apply();
        @(negedge clk);
        check("intra_same_rd", issue_ok, 2'b01);
        tick();
        idle(); set_slot(0, 1, 1, 10, 1, 0, 0, 1); set_slot(1, 1, 1, 11, 2, 3, 4, 1); apply();
        @(negedge clk);
        check("dual_fire_ok", issue_ok, 2'b11);
        tick();
        idle(); set_slot(0, 1, 0, 0, 0, 10, 0, 0); set_slot(1, 1, 0, 0, 0, 11, 0, 0); apply();
        @(negedge clk);
        check("dual_raw_both", issue_ok, 2'b00);
        check("dual_busy", busy_vec[11:10], 2'b11);
        tick();
        @(negedge clk);
        check("dual_raw_slot1", issue_ok, 2'b01);
        tick();

        // WAW: x3 with cnt 4 blocks a lat-1 rewrite until cnt<=1; slot 1 follows in-order.
        idle(); set_slot(0, 1, 1, 3, 4, 0, 0, 1); apply(); tick();
        idle(); set_slot(0, 1, 1, 3, 1, 0, 0, 0); set_slot(1, 1, 0, 0, 0, 1, 0, 0); apply();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("waw_block", issue_ok, 2'b00);
            tick();
        end
        @(negedge clk);
        check("waw_release", issue_ok, 2'b11);
        tick();

        // Reset again so the stall count starts from zero.
        idle(); rst = 1'b1; tick(); tick(); rst = 1'b0;
        @(negedge clk);
        check("rst2_busy_vec", busy_vec, 32'h0);
        tick();

        // 7 stalls on x20, then 3 on x21, then a stalled cycle under flush (not counted).
        idle(); set_slot(0, 1, 1, 20, 7, 0, 0, 1); set_slot(1, 1, 1, 22, 5, 0, 0, 1); apply(); tick();
        idle(); set_slot(0, 1, 0, 0, 0, 20, 0, 0); apply();
        repeat (7) tick();
        idle(); set_slot(0, 1, 1, 21, 4, 20, 0, 1); apply();
        @(negedge clk);
        check("x20_bypass", issue_ok[0], 1'b1);
        tick();
        idle(); set_slot(0, 1, 0, 0, 0, 21, 0, 0); apply();
        repeat (3) tick();
        flush = 1'b1;
        @(negedge clk);
        check("pre_flush_busy", busy_vec, 32'h0070_0000);
`ifdef SCOREBOARD_PERF_EN
        check("stall_10", stall_cycles, 64'd10);
`endif
        tick();
        idle(); set_slot(0, 1, 1, 24, 3, 0, 0, 1); set_slot(1, 1, 1, 25, 2, 0, 0, 1); apply();
        @(negedge clk);
        check("flush_clear", busy_vec, 32'h0);
`ifdef SCOREBOARD_PERF_EN
        check("stall_after_flush", stall_cycles, 64'd10);
`endif
        tick();
        idle(); flush = 1'b1; set_slot(0, 1, 1, 26, 2, 0, 0, 1); apply();
        @(negedge clk);
        check("pre_flush_fire_busy", busy_vec, 32'h0300_0000);
        tick();
        idle();
        @(negedge clk);
        check("flush_ignores_fire", busy_vec, 32'h0);
`ifdef SCOREBOARD_PERF_EN
        check("stall_final", stall_cycles, 64'd10);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
